// File: rtl/axi_w_pkg.sv
// Shared types for the AXI W-channel FIFO drain: beat layout, FIFO word width, check FSM states.
package axi_w_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int FIFO_W = DATA_W + STRB_W + 1;
  localparam int LEN_W  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_beat_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } w_chk_state_e;

  function automatic w_beat_t unpack_word(input logic [FIFO_W-1:0] i_word);
    return w_beat_t'(i_word);
  endfunction

endpackage

// File: rtl/axi_w_fifo_drain_w_skid_buf.sv
// Two-entry beat buffer between the FIFO read port and the W channel.
// Head/tail are single-bit indices; push and pop in the same cycle leave the count unchanged.
module w_skid_buf
  import axi_w_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  w_beat_t    i_push_beat,
  input  logic       i_pop,
  output logic [1:0] o_count,
  output w_beat_t    o_head
);

  w_beat_t    r_mem [2];
  logic       r_head;
  logic       r_tail;
  logic [1:0] r_count;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_beat;
        r_tail        <= ~r_tail;
      end
      if (i_pop) begin
        r_head <= ~r_head;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

endmodule

// File: rtl/axi_w_fifo_drain.sv
// Read-side drain of the AXI write-data CDC FIFO onto a W channel, through a 2-entry buffer.
// Optional burst-length / wlast checker enabled by defining W_LAST_CHECK_EN.
module axi_w_fifo_drain
  import axi_w_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fifo_not_empty,
  input  logic [FIFO_W-1:0] i_fifo_r_data,
  output logic              o_fifo_rd_en,
`ifdef W_LAST_CHECK_EN
  input  logic              i_len_valid,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_len_ready,
  output logic              o_last_err,
`endif
  input  logic              i_wready,
  output logic              o_wvalid,
  output logic [DATA_W-1:0] o_wdata,
  output logic [STRB_W-1:0] o_wstrb,
  output logic              o_wlast
);

  logic [1:0] w_count;
  w_beat_t    w_head;
  w_beat_t    w_push_beat;
  logic       w_rd_en;
  logic       w_wvalid;
  logic       w_hs;

  // Pop decision uses only the registered occupancy, so wready never reaches fifo_rd_en.
  assign w_rd_en     = i_fifo_not_empty && (w_count < 2'd2) && !rst;
  assign w_push_beat = unpack_word(i_fifo_r_data);
  assign w_hs        = w_wvalid && i_wready;

  w_skid_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_rd_en),
    .i_push_beat (w_push_beat),
    .i_pop       (w_hs),
    .o_count     (w_count),
    .o_head      (w_head)
  );

`ifdef W_LAST_CHECK_EN
  w_chk_state_e     r_state;
  logic [LEN_W-1:0] r_exp_len;
  logic [LEN_W-1:0] r_beat_cnt;
  logic             r_last_err;
  logic             w_final;

  assign w_final     = (r_beat_cnt == r_exp_len);
  assign w_wvalid    = (w_count != 2'd0) && (r_state == BURST);
  assign o_len_ready = (r_state == IDLE) || (w_hs && w_final);
  assign o_last_err  = r_last_err;

  // Burst tracking: the length count, not wlast, decides where a burst ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_exp_len  <= '0;
      r_beat_cnt <= '0;
      r_last_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_len_valid) begin
            r_state    <= BURST;
            r_exp_len  <= i_len;
            r_beat_cnt <= '0;
          end
        end
        BURST: begin
          if (w_hs) begin
            if (w_head.last != w_final) begin
              r_last_err <= 1'b1;
            end
            if (w_final) begin
              r_beat_cnt <= '0;
              if (i_len_valid) begin
                r_exp_len <= i_len;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`else
  assign w_wvalid = (w_count != 2'd0);
`endif

  assign o_fifo_rd_en = w_rd_en;
  assign o_wvalid     = w_wvalid;
  assign o_wdata      = w_head.data;
  assign o_wstrb      = w_head.strb;
  assign o_wlast      = w_head.last;

endmodule

// File: tb/tb_axi_w_fifo_drain.sv
// Directed bench for axi_w_fifo_drain; the bench itself models the CDC FIFO as a queue.
module tb_axi_w_fifo_drain;
  import axi_w_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              fifo_not_empty;
  logic [FIFO_W-1:0] fifo_r_data;
  logic              o_fifo_rd_en;
  logic              len_valid;
  logic [LEN_W-1:0]  len;
  logic              o_len_ready;
  logic              o_last_err;
  logic              wready;
  logic              o_wvalid;
  logic [DATA_W-1:0] o_wdata;
  logic [STRB_W-1:0] o_wstrb;
  logic              o_wlast;

  logic [FIFO_W-1:0] q [$];
  int n_chk  = 0;
  int n_fail = 0;

  logic              ob_rd, ob_v, ob_l, ob_lr, ob_err;
  logic [DATA_W-1:0] ob_d;
  logic [STRB_W-1:0] ob_s;

  always #5 clk = ~clk;

  axi_w_fifo_drain dut (
    .clk              (clk),
    .rst              (rst),
    .i_fifo_not_empty (fifo_not_empty),
    .i_fifo_r_data    (fifo_r_data),
    .o_fifo_rd_en     (o_fifo_rd_en),
`ifdef W_LAST_CHECK_EN
    .i_len_valid      (len_valid),
    .i_len            (len),
    .o_len_ready      (o_len_ready),
    .o_last_err       (o_last_err),
`endif
    .i_wready         (wready),
    .o_wvalid         (o_wvalid),
    .o_wdata          (o_wdata),
    .o_wstrb          (o_wstrb),
    .o_wlast          (o_wlast)
  );

`ifndef W_LAST_CHECK_EN
  assign o_len_ready = 1'b0;
  assign o_last_err  = 1'b0;
`endif

  typedef struct {
    bit                wr;
    bit                rd;
    bit                v;
    logic [DATA_W-1:0] d;
    bit                l;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [DATA_W-1:0] dat(input int k);
    return 32'hA500_0000 + 32'(k);
  endfunction

  function automatic logic [STRB_W-1:0] stb(input int k);
    logic [31:0] kk;
    kk = 32'(k);
    return kk[3:0] ^ 4'hF;
  endfunction

  task automatic push(input int k, input bit last);
    q.push_back({dat(k), stb(k), last});
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: present FIFO head, observe outputs before the edge, pop the model on a read.
  task automatic tick(input bit wr, input bit lv, input logic [LEN_W-1:0] ln);
    bit pop;
    wready         = wr;
    len_valid      = lv;
    len            = ln;
    fifo_not_empty = (q.size() != 0);
    fifo_r_data    = (q.size() != 0) ? q[0] : '0;
    #1;
    ob_rd  = o_fifo_rd_en;
    ob_v   = o_wvalid;
    ob_d   = o_wdata;
    ob_s   = o_wstrb;
    ob_l   = o_wlast;
    ob_lr  = o_len_ready;
    ob_err = o_last_err;
    pop    = ob_rd && fifo_not_empty;
    @(posedge clk);
    if (pop) q.delete(0);
    #1;
  endtask

  task automatic chk_beat(input string nm, input bit v, input int k, input bit l);
    chk({nm, ".wvalid"}, 64'(ob_v), 64'(v));
    if (v) begin
      chk({nm, ".wdata"}, 64'(ob_d), 64'(dat(k)));
      chk({nm, ".wstrb"}, 64'(ob_s), 64'(stb(k)));
      chk({nm, ".wlast"}, 64'(ob_l), 64'(l));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wready = 1'b0; len_valid = 1'b0; len = '0;
    fifo_not_empty = 1'b0; fifo_r_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Empty FIFO after reset.
    tick(1'b1, 1'b0, '0);
    chk("rst.rd_en", 64'(ob_rd), 64'd0);
    chk("rst.wvalid", 64'(ob_v), 64'd0);
    chk("rst.wdata", 64'(ob_d), 64'd0);
    chk("rst.wstrb", 64'(ob_s), 64'd0);
    chk("rst.wlast", 64'(ob_l), 64'd0);
`ifdef W_LAST_CHECK_EN
    chk("rst.last_err", 64'(ob_err), 64'd0);
`endif

    // Back-pressure: 4 words, wready low, then released.
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'hA500_0000, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'hA500_0000, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 32'hA500_0000, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'hA500_0000, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'hA500_0001, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'hA500_0002, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 32'hA500_0003, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    for (int k = 0; k < 4; k++) push(k, k == 3);
    for (int i = 0; i < 9; i++) begin
      tick(tbl[i].wr, i == 0, 4'd3);
      chk($sformatf("stall[%0d].rd_en", i), 64'(ob_rd), 64'(tbl[i].rd));
      chk($sformatf("stall[%0d].wvalid", i), 64'(ob_v), 64'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("stall[%0d].wdata", i), 64'(ob_d), 64'(tbl[i].d));
        chk($sformatf("stall[%0d].wlast", i), 64'(ob_l), 64'(tbl[i].l));
      end
    end

    // Eight-beat stream at full rate.
    for (int k = 0; k < 8; k++) push(100 + k, k == 7);
    for (int c = 0; c < 10; c++) begin
      tick(1'b1, c == 0, 4'd7);
      chk($sformatf("strm[%0d].rd_en", c), 64'(ob_rd), 64'(c <= 7));
      chk_beat($sformatf("strm[%0d]", c), (c >= 1) && (c <= 8), 100 + c - 1, c == 8);
    end
`ifdef W_LAST_CHECK_EN
    chk("strm.last_err", 64'(ob_err), 64'd0);

    // Early wlast on beat 2 of a 4-beat burst.
    for (int k = 0; k < 4; k++) push(10 + k, k == 1);
    tick(1'b1, 1'b1, 4'd3);
    chk("mis[0].len_ready", 64'(ob_lr), 64'd1);
    tick(1'b1, 1'b0, '0);
    chk_beat("mis[1]", 1'b1, 10, 1'b0);
    chk("mis[1].last_err", 64'(ob_err), 64'd0);
    tick(1'b1, 1'b0, '0);
    chk_beat("mis[2]", 1'b1, 11, 1'b1);
    chk("mis[2].last_err", 64'(ob_err), 64'd0);
    tick(1'b1, 1'b0, '0);
    chk_beat("mis[3]", 1'b1, 12, 1'b0);
    chk("mis[3].last_err", 64'(ob_err), 64'd1);
    chk("mis[3].len_ready", 64'(ob_lr), 64'd0);
    tick(1'b1, 1'b0, '0);
    chk_beat("mis[4]", 1'b1, 13, 1'b0);
    chk("mis[4].len_ready", 64'(ob_lr), 64'd1);
    tick(1'b1, 1'b0, '0);
    chk("mis[5].wvalid", 64'(ob_v), 64'd0);
    chk("mis[5].last_err", 64'(ob_err), 64'd1);
    chk("mis[5].len_ready", 64'(ob_lr), 64'd1);
    do_reset();

    // len=0 then len=1 back-to-back, no bubble.
    push(20, 1'b1); push(21, 1'b0); push(22, 1'b1);
    tick(1'b1, 1'b1, 4'd0);
    chk("b2b[0].len_ready", 64'(ob_lr), 64'd1);
    tick(1'b1, 1'b1, 4'd1);
    chk_beat("b2b[1]", 1'b1, 20, 1'b1);
    chk("b2b[1].len_ready", 64'(ob_lr), 64'd1);
    tick(1'b1, 1'b0, '0);
    chk_beat("b2b[2]", 1'b1, 21, 1'b0);
    chk("b2b[2].len_ready", 64'(ob_lr), 64'd0);
    tick(1'b1, 1'b0, '0);
    chk_beat("b2b[3]", 1'b1, 22, 1'b1);
    chk("b2b[3].len_ready", 64'(ob_lr), 64'd1);
    tick(1'b1, 1'b0, '0);
    chk("b2b[4].wvalid", 64'(ob_v), 64'd0);
    chk("b2b[4].last_err", 64'(ob_err), 64'd0);
`endif

    // Reset mid-burst with the buffer full.
    push(30, 1'b0); push(31, 1'b0); push(32, 1'b1);
    tick(1'b0, 1'b1, 4'd2);
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    chk("mid.rd_en_full", 64'(ob_rd), 64'd0);
    chk_beat("mid.held", 1'b1, 30, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid.rst.wvalid", 64'(o_wvalid), 64'd0);
    chk("mid.rst.rd_en", 64'(o_fifo_rd_en), 64'd0);
    chk("mid.rst.wdata", 64'(o_wdata), 64'd0);
    chk("mid.rst.last_err", 64'(o_last_err), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    push(40, 1'b0); push(41, 1'b1);
    tick(1'b1, 1'b1, 4'd1);
    chk("post[0].rd_en", 64'(ob_rd), 64'd1);
    chk("post[0].wvalid", 64'(ob_v), 64'd0);
    tick(1'b1, 1'b0, '0);
    chk_beat("post[1]", 1'b1, 40, 1'b0);
    tick(1'b1, 1'b0, '0);
    chk_beat("post[2]", 1'b1, 41, 1'b1);
    tick(1'b1, 1'b0, '0);
    chk("post[3].wvalid", 64'(ob_v), 64'd0);
    chk("post[3].last_err", 64'(ob_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
